// File: rtl/ser8_pkg.sv
// Shared types and line-level constants for the 8-bit serial frame transmitter.
package ser8_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_LVL = 1'b0;
  localparam logic        STOP_LVL  = 1'b1;

endpackage

// File: rtl/ser8_bit_tick.sv
// Bit-period divider: tick is high on the last cycle of each DIV-cycle period.
module ser8_bit_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned    CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  // Reloading on tick keeps the count inside 0..DIV-1; with DIV=1 it sits at 0.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ser8_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, 8 data bits MSB first,
// optional even parity, stop bit; each bit lasts DIV clock cycles.
module ser8_frame_tx
  import ser8_pkg::*;
#(
  parameter int unsigned DIV    = 4,
  parameter bit          PAR_EN = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d,
  input  logic       d_vld,
  output logic       d_rdy,
  output logic       sout,
  output logic       busy,
  output logic       done
);

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic                   par_q, par_d;
  logic                   tick;

  // Holding the divider in restart while idle aligns the first period to acceptance.
  ser8_bit_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(state_q == IDLE),
    .tick   (tick)
  );

  assign d_rdy = (state_q == IDLE);
  assign busy  = ~d_rdy;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    sout     = STOP_LVL;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_vld) begin
          shreg_d  = d;
          par_d    = ^d;
          bitcnt_d = '0;
          state_d  = START;
        end
      end
      START: begin
        sout = START_LVL;
        if (tick) state_d = DATA;
      end
      DATA: begin
        sout = shreg_q[DATA_BITS-1];
        if (tick) begin
          shreg_d  = {shreg_q[DATA_BITS-2:0], 1'b0};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'(DATA_BITS - 1)) state_d = PAR_EN ? PAR : STOP;
        end
      end
      PAR: begin
        sout = par_q;
        if (tick) state_d = STOP;
      end
      STOP: begin
        sout = STOP_LVL;
        if (tick) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
    end
  end

endmodule

// File: tb/tb_ser8_frame_tx.sv
// Directed bench for ser8_frame_tx across three parameter sets (DIV=4, DIV=2+parity, DIV=1).
module tb_ser8_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d4 = '0, d2 = '0, d1 = '0;
  logic       v4 = 1'b0, v2 = 1'b0, v1 = 1'b0;
  logic       rdy4, so4, bsy4, dn4;
  logic       rdy2, so2, bsy2, dn2;
  logic       rdy1, so1, bsy1, dn1;

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  ser8_frame_tx #(.DIV(4), .PAR_EN(1'b0)) u4 (
    .clk(clk), .reset(rst), .d(d4), .d_vld(v4),
    .d_rdy(rdy4), .sout(so4), .busy(bsy4), .done(dn4));

  ser8_frame_tx #(.DIV(2), .PAR_EN(1'b1)) u2 (
    .clk(clk), .reset(rst), .d(d2), .d_vld(v2),
    .d_rdy(rdy2), .sout(so2), .busy(bsy2), .done(dn2));

  ser8_frame_tx #(.DIV(1), .PAR_EN(1'b0)) u1 (
    .clk(clk), .reset(rst), .d(d1), .d_vld(v1),
    .d_rdy(rdy1), .sout(so1), .busy(bsy1), .done(dn1));

  // Expected line level on cycle k (1-based, counted from the cycle after acceptance).
  function automatic logic exp_sout(input logic [7:0] data, input int div,
                                    input bit par, input int k);
    int b;
    b = (k - 1) / div;
    if (b == 0) return 1'b0;
    if (b <= 8) return data[8 - b];
    if (par && b == 9) return ^data;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d4 = 8'($urandom); d2 = 8'($urandom); d1 = 8'($urandom);
      step();
      tests_run++;
      if ({so4, rdy4, bsy4, dn4} !== 4'b1100) begin
        failures++;
        $display("FAIL reset_idle_u4 cyc %0d: got sout/rdy/busy/done=%b want 1100", i, {so4, rdy4, bsy4, dn4});
      end
      tests_run++;
      if ({so2, rdy2, bsy2, dn2} !== 4'b1100) begin
        failures++;
        $display("FAIL reset_idle_u2 cyc %0d: got %b want 1100", i, {so2, rdy2, bsy2, dn2});
      end
      tests_run++;
      if ({so1, rdy1, bsy1, dn1} !== 4'b1100) begin
        failures++;
        $display("FAIL reset_idle_u1 cyc %0d: got %b want 1100", i, {so1, rdy1, bsy1, dn1});
      end
    end
  endtask

  task automatic test_basic_frame(input logic [7:0] data);
    d4 = data; v4 = 1'b1;
    step();
    v4 = 1'b0;
    for (int k = 1; k <= 41; k++) begin
      if (k <= 40) begin
        tests_run++;
        if (so4 !== exp_sout(data, 4, 1'b0, k) || dn4 !== (k == 40) || bsy4 !== 1'b1) begin
          failures++;
          $display("FAIL frame_%h cyc %0d: got sout=%b done=%b busy=%b want sout=%b done=%b busy=1",
                   data, k, so4, dn4, bsy4, exp_sout(data, 4, 1'b0, k), (k == 40));
        end
      end else begin
        tests_run++;
        if ({rdy4, dn4, so4} !== 3'b101) begin
          failures++;
          $display("FAIL frame_%h_end: got rdy/done/sout=%b want 101", data, {rdy4, dn4, so4});
        end
      end
      d4 = 8'($urandom);
      step();
    end
  endtask

  task automatic test_parity();
    int dn_cnt;
    dn_cnt = 0;
    d2 = 8'h07; v2 = 1'b1;
    step();
    v2 = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (dn2) dn_cnt++;
      if (k <= 22) begin
        tests_run++;
        if (so2 !== exp_sout(8'h07, 2, 1'b1, k) || dn2 !== (k == 22)) begin
          failures++;
          $display("FAIL parity_frame cyc %0d: got sout=%b done=%b want sout=%b done=%b",
                   k, so2, dn2, exp_sout(8'h07, 2, 1'b1, k), (k == 22));
        end
      end
      if (k == 19) begin
        tests_run++;
        if (so2 !== 1'b1) begin
          failures++;
          $display("FAIL parity_bit: got %b want 1", so2);
        end
      end
      step();
    end
    tests_run++;
    if (dn_cnt != 1) begin
      failures++;
      $display("FAIL parity_done_count: got %0d want 1", dn_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic exp;
    d1 = 8'hFF; v1 = 1'b1;
    step();
    for (int k = 1; k <= 22; k++) begin
      if (k <= 10)      exp = exp_sout(8'hFF, 1, 1'b0, k);
      else if (k == 11) exp = 1'b1;
      else if (k <= 21) exp = exp_sout(8'h00, 1, 1'b0, k - 11);
      else              exp = 1'b1;
      tests_run++;
      if (so1 !== exp || dn1 !== (k == 10 || k == 21) || rdy1 !== (k == 11 || k == 22)) begin
        failures++;
        $display("FAIL b2b cyc %0d: got sout=%b done=%b rdy=%b want sout=%b done=%b rdy=%b",
                 k, so1, dn1, rdy1, exp, (k == 10 || k == 21), (k == 11 || k == 22));
      end
      if (k == 1) d1 = 8'h00;
      if (k == 5) d1 = 8'h5A;
      if (k == 9) d1 = 8'h00;
      if (k == 12) v1 = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid();
    int dn_cnt;
    dn_cnt = 0;
    d4 = 8'h3C; v4 = 1'b1;
    step();
    v4 = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tests_run++;
      if (so4 !== exp_sout(8'h3C, 4, 1'b0, k)) begin
        failures++;
        $display("FAIL mid_pre cyc %0d: got sout=%b want %b", k, so4, exp_sout(8'h3C, 4, 1'b0, k));
      end
      if (k == 18) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    tests_run++;
    if ({so4, rdy4, bsy4, dn4} !== 4'b1100) begin
      failures++;
      $display("FAIL mid_after_reset: got sout/rdy/busy/done=%b want 1100", {so4, rdy4, bsy4, dn4});
    end
    for (int i = 0; i < 50; i++) begin
      if (dn4 || so4 !== 1'b1) dn_cnt++;
      step();
    end
    tests_run++;
    if (dn_cnt != 0) begin
      failures++;
      $display("FAIL mid_no_done: got %0d bad idle cycles want 0", dn_cnt);
    end
    test_basic_frame(8'h81);
  endtask

  initial begin
    test_reset();
    test_basic_frame(8'hA5);
    test_parity();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
